// File: rtl/pkt_bus_arb.sv
// Credit-based round-robin arbiter: N_REQ requesters share a packet bus toward
// a TX side that hands out CREDIT_MAX credits, with a registered one-beat output.
module pkt_bus_arb #(
  parameter  int N_REQ      = 4,
  parameter  int DATA_W     = 32,
  parameter  int CREDIT_MAX = 8,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W      = $clog2(CREDIT_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     credit_ret,
  output logic                     bus_valid,
  output logic [DATA_W-1:0]        bus_data,
  output logic [IDX_W-1:0]         bus_id,
  output logic [CNT_W-1:0]         credit_cnt,
  output logic [15:0]              stall_cnt,
  output logic                     cred_err
);

  typedef enum logic [1:0] {INIT, RUN, STALL} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             grant;

  // Round-robin search starting one past the last winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    found   = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A credit returned this cycle only shows up in credit_cnt next cycle.
  assign grant = (state == RUN) && (credit_cnt != '0) && found && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state      <= INIT;
      ptr        <= IDX_W'(N_REQ - 1);
      credit_cnt <= CNT_W'(CREDIT_MAX);
      bus_valid  <= 1'b0;
      bus_data   <= '0;
      bus_id     <= '0;
      stall_cnt  <= '0;
      cred_err   <= 1'b0;
    end else begin
      bus_valid <= grant;
      if (grant) begin
        bus_data <= req_data[gnt_idx*DATA_W +: DATA_W];
        bus_id   <= gnt_idx;
        ptr      <= gnt_idx;
      end

      if (credit_ret && !grant && credit_cnt == CNT_W'(CREDIT_MAX))
        cred_err <= 1'b1;
      else if (grant && !credit_ret)
        credit_cnt <= credit_cnt - CNT_W'(1);
      else if (!grant && credit_ret)
        credit_cnt <= credit_cnt + CNT_W'(1);

      if (state == STALL && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;

      case (state)
        INIT:    state <= RUN;
        RUN:     if (credit_cnt == '0 && |req_valid) state <= STALL;
        STALL:   if (credit_cnt != '0) state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/pkt_bus_arb.md
PKT_BUS_ARB -- requirements
Module: pkt_bus_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of packet requesters sharing the packet bus TX.
REQ-002 Parameter DATA_W, default 32: packet payload width.
REQ-003 Parameter CREDIT_MAX, default 8: credits held by the TX side after reset.
REQ-004 Derived widths: IDX_W = max(1, clog2(N_REQ)); CNT_W = clog2(CREDIT_MAX+1).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  N_REQ  per-requester packet pending; bit i held with req_data until accepted.
REQ-008 req_data  in  N_REQ*DATA_W  requester i payload at bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  out  N_REQ  one-hot-or-zero grant; combinational from current state and req_valid.
REQ-010 credit_ret  in  1  single-cycle pulse returning one credit from RX.
REQ-011 bus_valid  out  1  registered; one packet beat on the bus.
REQ-012 bus_data  out  DATA_W  registered payload of the granted requester.
REQ-013 bus_id  out  IDX_W  registered index of the granted requester.
REQ-014 credit_cnt  out  CNT_W  current available credits.
REQ-015 stall_cnt  out  16  saturating count of STALL cycles.
REQ-016 cred_err  out  1  sticky; credit returned while credit_cnt == CREDIT_MAX.

Function
REQ-017 FSM states: INIT, RUN and STALL.
REQ-018 INIT transitions:
- Entered on reset.
- Issues no grants.
- Goes to RUN the next cycle.
REQ-019 RUN to STALL: credit_cnt == 0 and req_valid != 0.
REQ-020 STALL to RUN: the cycle after credit_cnt becomes nonzero.
REQ-021 Grant condition:
- Grant only in RUN.
- Requires credit_cnt > 0 and at least one req_valid bit.
- A credit returned in the same cycle is not usable until the next cycle.
REQ-022 Round-robin arbitration:
- Search starts at index ptr+1 mod N_REQ.
- The first valid requester wins.
- On grant, ptr <= granted index.
- ptr is unchanged when there is no grant.
REQ-023 Handshake: a transfer occurs when req_valid[i] & req_ready[i]; at most one per cycle.
REQ-024 Bus output latency: exactly 1 cycle.
- bus_valid, bus_data and bus_id are registered from the transfer.
- bus_valid = 0 in cycles with no transfer.
REQ-025 bus_data and bus_id hold their previous values when bus_valid = 0.
REQ-026 Credit arithmetic: credit_cnt_next = credit_cnt - grant + credit_ret.
- Grant and return in the same cycle leave credit_cnt unchanged.
REQ-027 Credit overflow:
- Applies when credit_ret = 1, credit_cnt == CREDIT_MAX and there is no grant.
- credit_cnt stays at CREDIT_MAX.
- cred_err <= 1.
REQ-028 credit_cnt never underflows, because a grant implies credit_cnt > 0.
REQ-029 stall_cnt:
- Increments each cycle in STALL.
- Saturates at 16'hFFFF.
- Never wraps.
REQ-030 Reset mid-packet: the in-flight bus_valid is dropped next cycle; no partial state is kept.

Reset
REQ-031 On rst = 1 at a clock edge:
- state = INIT, ptr = N_REQ-1 (requester 0 is first).
- credit_cnt = CREDIT_MAX.
- bus_valid = 0, bus_data = 0, bus_id = 0.
- stall_cnt = 0, cred_err = 0.
REQ-032 req_ready = 0 while rst is high and while in INIT.
REQ-033 rst takes priority over every simultaneous event, including credit_ret and a pending grant.

Verification
REQ-034 Reset release with req_valid=4'b0001 -> no grant in INIT; next cycle req_ready=4'b0001; following cycle bus_valid=1, bus_id=0, credit_cnt=7.
REQ-035 req_valid=4'b1111 held for 4 granting cycles, credit_ret each cycle -> grants 0,1,2,3 in order; credit_cnt stays 8.
REQ-036 req_valid=4'b0101, no credit_ret, 8 grants issued -> credit_cnt=0, state STALL, stall_cnt increments; one credit_ret pulse -> RUN next cycle, one grant, credit_cnt back to 0.
REQ-037 credit_ret with credit_cnt=8 and idle requesters -> credit_cnt=8, cred_err=1 and remains 1 until rst.
REQ-038 credit_cnt=1 with grant and credit_ret in the same cycle -> credit_cnt=1; the returned credit is unused in that cycle.
REQ-039 rst asserted in the cycle after a transfer -> bus_valid=0 the next cycle, credit_cnt=8, ptr restarts at requester 0.
